binary_to_gray: RTL and testbench

BINARY_TO_GRAY -- requirements
Module: binary_to_gray

---
 rtl/binary_to_gray.sv | 71 +++++++
 tb/tb_binary_to_gray.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/binary_to_gray.sv
// Registered binary->Gray encoder and Gray->binary decoder, independent 1-cycle paths.
// Define BINARY_TO_GRAY_RT_CHECK_EN to add a sticky round-trip checker driving rt_error.
module binary_to_gray #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_valid,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             gray_valid,
  input  logic             dec_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             rt_error
);

  // MSB-first prefix XOR; each bit depends on all higher Gray bits.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
    return b;
  endfunction

  logic [WIDTH-1:0] enc_w;
  logic [WIDTH-1:0] dec_w;

  assign enc_w[WIDTH-1] = bin[WIDTH-1];
  for (genvar i = 0; i < WIDTH-1; i++) begin : g_enc
    assign enc_w[i] = bin[i] ^ bin[i+1];
  end

  assign dec_w = g2b(gray_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      gray       <= '0;
      gray_valid <= 1'b0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
    end else begin
      gray_valid <= enc_valid;
      bin_valid  <= dec_valid;
      if (enc_valid) gray    <= enc_w;
      if (dec_valid) bin_out <= dec_w;
    end
  end

`ifdef BINARY_TO_GRAY_RT_CHECK_EN
  logic [WIDTH-1:0] bin_q;
  logic             rt_err_q;

  // bin_q lines up with gray: both capture on the same accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      rt_err_q <= 1'b0;
    end else begin
      if (enc_valid) bin_q <= bin;
      if (gray_valid && (g2b(gray) != bin_q)) rt_err_q <= 1'b1;
    end
  end

  assign rt_error = rt_err_q;
`else
  assign rt_error = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed + scoreboard bench for binary_to_gray (WIDTH=32, default build).
module tb_binary_to_gray;
  localparam int W = 32;
  typedef logic [W-1:0] w_t;

  logic clk = 1'b0;
  logic rst, enc_valid, dec_valid;
  w_t   bin, gray_in, gray, bin_out;
  logic gray_valid, bin_valid, rt_error;

  int errs = 0;
  int checks = 0;
  w_t enc_q[$];
  w_t dec_q[$];
  w_t exp_gray, exp_bin;

  always #5 clk = ~clk;

  binary_to_gray #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .bin(bin), .gray(gray), .gray_valid(gray_valid),
    .dec_valid(dec_valid), .gray_in(gray_in), .bin_out(bin_out), .bin_valid(bin_valid),
    .rt_error(rt_error)
  );

  function automatic w_t m_enc(input w_t b);
    w_t r;
    for (int i = 0; i < W-1; i++) r[i] = b[i] ^ b[i+1];
    r[W-1] = b[W-1];
    return r;
  endfunction

  function automatic w_t m_dec(input w_t g);
    w_t r;
    r[W-1] = g[W-1];
    for (int i = W-2; i >= 0; i--) r[i] = g[i] ^ r[i+1];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat, clock it, then compare every output against the model.
  task automatic step(input logic r, input logic ev, input w_t b,
                      input logic dv, input w_t g, input w_t dexp);
    rst = r; enc_valid = ev; bin = b; dec_valid = dv; gray_in = g;
    if (!r && ev) enc_q.push_back(m_enc(b));
    if (!r && dv) dec_q.push_back(dexp);
    @(posedge clk); #1;
    if (r) begin
      exp_gray = '0;
      exp_bin  = '0;
    end else begin
      if (ev) begin
        if (enc_q.size() == 0) chk("enc_q_underflow", 1, 0);
        else exp_gray = enc_q.pop_front();
      end
      if (dv) begin
        if (dec_q.size() == 0) chk("dec_q_underflow", 1, 0);
        else exp_bin = dec_q.pop_front();
      end
    end
    chk("gray_valid", gray_valid, ev && !r);
    chk("bin_valid", bin_valid, dv && !r);
    chk("gray", gray, exp_gray);
    chk("bin_out", bin_out, exp_bin);
    chk("rt_error", rt_error, 1'b0);
  endtask

  initial begin
    w_t prev_gray, g;
    rst = 1'b1; enc_valid = 1'b0; dec_valid = 1'b0; bin = '0; gray_in = '0;
    exp_gray = '0; exp_bin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gray", gray, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_gray_valid", gray_valid, 0);
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_rt_error", rt_error, 0);

    // First beat after reset, both paths at once
    step(0, 1, 32'hAAAAAAAA, 1, 32'hFFFFFFFF, 32'hAAAAAAAA);
    chk("aa_gray_const", gray, 32'hFFFFFFFF);
    chk("ff_dec_const", bin_out, 32'hAAAAAAAA);

    // Chain encoded output back into the decoder
    step(0, 1, 32'h1234_5678, 0, '0, '0);
    g = gray;
    step(0, 0, 32'hDEAD_BEEF, 1, g, 32'h1234_5678);
    chk("chain_roundtrip", bin_out, 32'h1234_5678);

    step(0, 1, 32'h0000_0000, 1, 32'h8000_0000, 32'hFFFFFFFF);
    chk("zero_gray", gray, 0);
    chk("msb_dec", bin_out, 32'hFFFFFFFF);
    step(0, 1, 32'hFFFF_FFFF, 0, '0, '0);
    chk("ones_gray", gray, 32'h8000_0000);

    // Hold with valids low and junk on the inputs
    step(0, 0, 32'h5555_1111, 0, 32'h0F0F_0F0F, '0);
    chk("hold_gray", gray, 32'h8000_0000);
    chk("hold_bin_out", bin_out, 32'hFFFFFFFF);

    // Count 0..0xFFFF after 0xFFFFFFFF (covers wrap to 0), chaining each gray back
    for (int i = 0; i <= 16'hFFFF; i++) begin
      prev_gray = gray;
      g = gray;
      step(0, 1, w_t'(i), 1, g, (i == 0) ? 32'hFFFF_FFFF : w_t'(i - 1));
      chk("one_bit_step", $countones(gray ^ prev_gray), 1);
    end

    // Random independent traffic
    for (int i = 0; i < 40; i++) begin
      w_t rb, rg;
      rb = $urandom; rg = $urandom;
      step(0, 1'($urandom_range(1)), rb, 1'($urandom_range(1)), rg, m_dec(rg));
    end

    // Reset mid-stream overrides both valids; next beat has normal latency
    step(0, 1, 32'hCAFE_F00D, 1, 32'h1357_9BDF, m_dec(32'h1357_9BDF));
    step(1, 1, 32'h0000_1234, 1, 32'h0000_5678, '0);
    chk("midrst_gray", gray, 0);
    chk("midrst_bin_out", bin_out, 0);
    step(0, 1, 32'h0000_0005, 1, 32'h0000_0007, 32'h0000_0005);
    chk("post_rst_gray", gray, 32'h0000_0007);
    chk("post_rst_bin", bin_out, 32'h0000_0005);

    chk("enc_q_empty", enc_q.size(), 0);
    chk("dec_q_empty", dec_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
